// File: rtl/panel_pkg.sv
// panel_pkg: front-panel key codes and a shared lowest-set-bit priority helper
package panel_pkg;
    localparam int KEY_CODE_W = 3;
    localparam logic [KEY_CODE_W-1:0] KEY_START     = 3'd0;
    localparam logic [KEY_CODE_W-1:0] KEY_STOP      = 3'd1;
    localparam logic [KEY_CODE_W-1:0] KEY_CONT      = 3'd2;
    localparam logic [KEY_CODE_W-1:0] KEY_EXAM      = 3'd3;
    localparam logic [KEY_CODE_W-1:0] KEY_DEP       = 3'd4;
    localparam logic [KEY_CODE_W-1:0] KEY_LOAD_ADDR = 3'd5;
    localparam logic [KEY_CODE_W-1:0] KEY_STEP      = 3'd6;
    localparam logic [KEY_CODE_W-1:0] KEY_CLEAR     = 3'd7;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) lowest_set = 4'(i);
    endfunction
endpackage

// File: rtl/key_sync.sv
// key_sync: two-flop synchroniser for asynchronous level inputs
module key_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {q, s1} <= '0;
        else          {q, s1} <= {s1, d};
endmodule

// File: rtl/panel_key_events.sv
// panel_key_events: debounced key levels to queued press events on a valid/ready handshake
// Optional auto-repeat of the lowest held key is built when KEYEV_REPEAT_EN is defined.
module panel_key_events
    import panel_pkg::*;
#(
    parameter int          NKEYS     = 8,
    parameter int          KW        = KEY_CODE_W,
    parameter logic [23:0] REP_DELAY = 24'd6000000,
    parameter logic [23:0] REP_RATE  = 24'd1500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] key_in,
    output logic [NKEYS-1:0] key_state,
    output logic             ev_valid,
    output logic [KW-1:0]    ev_code,
    input  logic             ev_ready,
    output logic             overrun
);
    logic [NKEYS-1:0] prev, pending, pending_nx, press, ld_mask, rep_set;
    logic [1:0]       arm_cnt;
    logic             armed, load;
    logic [KW-1:0]    sel;

    if (KW != $clog2(NKEYS) || NKEYS < 2 || NKEYS > 16) begin : g_bad_keys
        $error("panel_key_events: NKEYS must be 2..16 and KW = clog2(NKEYS)");
    end
    if (REP_RATE == 24'd0 || REP_RATE > REP_DELAY) begin : g_bad_rep
        $error("panel_key_events: need 0 < REP_RATE <= REP_DELAY");
    end

    key_sync #(.W(NKEYS)) u_sync (.clk(clk), .reset_n(reset_n), .d(key_in), .q(key_state));

    always_comb begin
        sel        = KW'(lowest_set(16'(pending)));
        press      = armed ? key_state & ~prev : '0;
        load       = |pending && (!ev_valid || ev_ready);
        ld_mask    = load ? NKEYS'(1) << sel : '0;
        pending_nx = (pending & ~ld_mask) | press | rep_set;
    end

`ifdef KEYEV_REPEAT_EN
    logic [23:0]   rep_cnt;
    logic [KW-1:0] rep_key, rep_key_q;
    logic          rep_any_q, rep_restart, rep_fire;

    // rep_cnt counts cycles the same key has been the lowest held key; it reloads after each repeat
    always_comb begin
        rep_key     = KW'(lowest_set(16'(key_state)));
        rep_restart = !rep_any_q || rep_key != rep_key_q;
        rep_fire    = armed && |key_state && !rep_restart && rep_cnt == REP_DELAY;
        rep_set     = rep_fire ? NKEYS'(1) << rep_key : '0;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rep_cnt   <= '0;
            rep_key_q <= '0;
            rep_any_q <= 1'b0;
        end else begin
            rep_any_q <= |key_state;
            rep_key_q <= rep_key;
            rep_cnt   <= !(|key_state) ? 24'd0
                       : rep_restart    ? 24'd1
                       : rep_fire       ? REP_DELAY - REP_RATE + 24'd1
                       : rep_cnt + {23'd0, rep_cnt != '1};
        end
`else
    assign rep_set = '0;
`endif

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            arm_cnt  <= '0;
            armed    <= 1'b0;
            prev     <= '0;
            pending  <= '0;
            ev_valid <= 1'b0;
            ev_code  <= '0;
            overrun  <= 1'b0;
        end else begin
            arm_cnt <= arm_cnt + {1'b0, arm_cnt != 2'd3};
            armed   <= armed | (arm_cnt == 2'd3);
            prev    <= key_state;
            pending <= pending_nx;
            overrun <= |(press & pending & ~ld_mask);
            if (load) begin
                ev_valid <= 1'b1;
                ev_code  <= sel;
            end else if (ev_ready) begin
                ev_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_panel_key_events.sv
// tb_panel_key_events: directed bench with an event-code scoreboard for panel_key_events
module tb_panel_key_events;
    logic       clk = 1'b0, reset_n = 1'b0, ev_ready = 1'b0;
    logic [7:0] key_in = '0, key_state;
    logic       ev_valid, overrun;
    logic [2:0] ev_code;
    int         n_pass = 0, n_total = 0, ov_cnt = 0, hits = 0, ov0 = 0;
    int         exp_q[$];
    int         seen[$];
`ifdef KEYEV_REPEAT_EN
    int         exp_hits[$] = '{4, 24, 29, 34, 39};
`else
    int         exp_hits[$] = '{4};
`endif

    panel_key_events #(.NKEYS(8), .KW(3), .REP_DELAY(24'd20), .REP_RATE(24'd5)) dut (
        .clk(clk), .reset_n(reset_n), .key_in(key_in), .key_state(key_state),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // accepted events are checked against the scoreboard; overrun pulses are tallied
    always @(negedge clk) begin
        if (reset_n && overrun) ov_cnt++;
        if (reset_n && ev_valid && ev_ready) begin
            if (exp_q.size() == 0) chk("unexpected_event", 32'(ev_code), 32'hff);
            else chk("event_code", 32'(ev_code), exp_q.pop_front());
        end
    end

    initial begin
        key_in[2] = 1'b1;
        #1;
        chk("rst_key_state", 32'(key_state), 0);
        chk("rst_ev_valid", 32'(ev_valid), 0);
        chk("rst_ev_code", 32'(ev_code), 0);
        chk("rst_overrun", 32'(overrun), 0);
        step(2);
        reset_n = 1'b1;
        step(1);
        chk("t1_state_c1", 32'(key_state[2]), 0);
        step(1);
        chk("t1_state_c2", 32'(key_state[2]), 1);
        hits = 0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (ev_valid) hits++;
        end
        chk("t1_held_no_event", hits, 0);
        key_in[2] = 1'b0;
        step(5);

        ev_ready = 1'b1;
        ov0 = ov_cnt;
        key_in[5] = 1'b1;
        exp_q.push_back(5);
        step(3);
        chk("t2_valid_e3", 32'(ev_valid), 0);
        step(1);
        chk("t2_valid_e4", 32'(ev_valid), 1);
        chk("t2_code_e4", 32'(ev_code), 5);
        step(1);
        chk("t2_valid_e5", 32'(ev_valid), 0);
        chk("t2_overrun", ov_cnt - ov0, 0);
        key_in[5] = 1'b0;
        step(5);

        key_in[1] = 1'b1;
        key_in[6] = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(6);
        step(4);
        chk("t3_valid_a", 32'(ev_valid), 1);
        chk("t3_code_a", 32'(ev_code), 1);
        step(1);
        chk("t3_valid_b", 32'(ev_valid), 1);
        chk("t3_code_b", 32'(ev_code), 6);
        step(1);
        chk("t3_valid_end", 32'(ev_valid), 0);
        key_in = '0;
        step(5);

        ev_ready = 1'b0;
        ov0 = ov_cnt;
        key_in[3] = 1'b1;
        exp_q.push_back(3);
        step(4);
        chk("t4_valid", 32'(ev_valid), 1);
        chk("t4_code", 32'(ev_code), 3);
        key_in[3] = 1'b0;
        step(4);
        key_in[3] = 1'b1;
        exp_q.push_back(3);
        step(6);
        chk("t4_second_no_ovr", ov_cnt - ov0, 0);
        chk("t4_code_stable", 32'(ev_code), 3);
        key_in[3] = 1'b0;
        step(4);
        key_in[3] = 1'b1;
        step(6);
        chk("t4_third_overrun", ov_cnt - ov0, 1);
        chk("t4_code_still", 32'(ev_code), 3);
        chk("t4_valid_still", 32'(ev_valid), 1);
        key_in = '0;
        ev_ready = 1'b1;
        step(10);
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_valid_end", 32'(ev_valid), 0);
        chk("t4_overrun_once", ov_cnt - ov0, 1);

        ev_ready = 1'b0;
        key_in[2:0] = 3'b111;
        exp_q.push_back(0);
        step(5);
        chk("t5_valid", 32'(ev_valid), 1);
        chk("t5_code", 32'(ev_code), 0);
        chk("t5_pending", 32'(dut.pending), 32'h06);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(ev_valid), 0);
        chk("t5_rst_pending", 32'(dut.pending), 0);
        chk("t5_rst_overrun", 32'(overrun), 0);
        exp_q.delete();
        step(2);
        reset_n = 1'b1;
        ev_ready = 1'b1;
        hits = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (ev_valid) hits++;
        end
        chk("t5_no_events", hits, 0);
        key_in = '0;
        step(10);

        for (int k = 0; k < exp_hits.size(); k++) exp_q.push_back(4);
        key_in[4] = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step(1);
            if (i == 40) key_in[4] = 1'b0;
            if (ev_valid) seen.push_back(i);
        end
        chk("t6_hit_count", seen.size(), exp_hits.size());
        for (int k = 0; k < exp_hits.size() && k < seen.size(); k++)
            chk($sformatf("t6_hit%0d_cycle", k), seen[k], exp_hits[k]);

        step(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
